// File: rtl/cpu_pkg.sv
// cpu_pkg: shared loader constants and state encoding
package cpu_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int CNT_W_DEF = 11;
  localparam logic [7:0] HDR_INST = 8'h00;
  localparam logic [7:0] HDR_DATA = 8'h01;
  localparam logic [7:0] HDR_RUN = 8'hFF;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_WRITE,
    ST_RUN
  } ld_state_e;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: MSB-first 8->32 byte packer with a one-cycle word_done on the 4th byte
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);
  logic [23:0] sh_q, sh_d;
  logic [1:0]  idx_q, idx_d;
  assign word = {sh_q, byte_in};
  assign word_done = en && idx_q == 2'd3;
  // shift in a byte and advance the byte index on every enabled byte
  always_comb begin
    sh_d = en ? {sh_q[15:0], byte_in} : sh_q;
    idx_d = en ? idx_q + 2'd1 : idx_q;
  end
  // byte history and index registers; a reset drops any partial word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_q <= '0;
      idx_q <= '0;
    end else begin
      sh_q <= sh_d;
      idx_q <= idx_d;
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: byte-stream frame loader that fills CPU instruction/data memory and gates CPU reset
module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       inst_data,
  output logic              write_instruction,
  output logic              write_data,
  output logic              busy,
  output logic              err
);
  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, address_q, address_d;
  logic [31:0]       inst_data_q, inst_data_d, word;
  logic              tgt_q, tgt_d, wr_i_q, wr_i_d, wr_d_q, wr_d_d, err_q, err_d;
  logic              acc, word_done;
  assign in_ready = state_q != ST_WRITE && state_q != ST_RUN;
  assign acc = in_valid && in_ready;
  assign cpu_rst = state_q != ST_RUN;
  assign busy = state_q != ST_IDLE && state_q != ST_RUN;
  assign address = address_q;
  assign inst_data = inst_data_q;
  assign write_instruction = wr_i_q;
  assign write_data = wr_d_q;
  assign err = err_q;
  word_assembler u_asm (
    .clk(clk),
    .rst(rst),
    .en(acc && state_q == ST_DATA),
    .byte_in(in_data),
    .word(word),
    .word_done(word_done)
  );
  // frame decoder: header/count/address parsing, word write scheduling, run control
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    tgt_d = tgt_q;
    err_d = err_q;
    address_d = word_done ? ptr_q : address_q;
    inst_data_d = word_done ? word : inst_data_q;
    wr_i_d = word_done && !tgt_q;
    wr_d_d = word_done && tgt_q;
    case (state_q)
      ST_IDLE:
        if (acc) begin
          if (in_data == HDR_INST || in_data == HDR_DATA) begin
            state_d = ST_CNT_HI;
            tgt_d = in_data == HDR_DATA;
          end else if (in_data == HDR_RUN) state_d = ST_RUN;
          else err_d = 1'b1;
        end
      ST_CNT_HI:
        if (acc) begin
          cnt_d = CNT_W'({in_data, 8'h00});
          state_d = ST_CNT_LO;
        end
      ST_CNT_LO:
        if (acc) begin
          cnt_d = cnt_q | CNT_W'(in_data);
          state_d = ST_ADDR_HI;
        end
      ST_ADDR_HI:
        if (acc) begin
          ptr_d = ADDR_W'({in_data, 8'h00});
          state_d = ST_ADDR_LO;
        end
      ST_ADDR_LO:
        if (acc) begin
          ptr_d = ptr_q | ADDR_W'(in_data);
          state_d = cnt_q == '0 ? ST_IDLE : ST_DATA;
        end
      ST_DATA: state_d = word_done ? ST_WRITE : ST_DATA;
      ST_WRITE: begin
        ptr_d = ptr_q + ADDR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
        state_d = cnt_q == CNT_W'(1) ? ST_IDLE : ST_DATA;
      end
      ST_RUN: state_d = load_req ? ST_IDLE : ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end
  // state and load-port registers; every load port comes straight from a flop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      tgt_q <= 1'b0;
      err_q <= 1'b0;
      address_q <= '0;
      inst_data_q <= '0;
      wr_i_q <= 1'b0;
      wr_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      tgt_q <= tgt_d;
      err_q <= err_d;
      address_q <= address_d;
      inst_data_q <= inst_data_d;
      wr_i_q <= wr_i_d;
      wr_d_q <= wr_d_d;
    end
endmodule
